// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe retiming pipeline.
package dff_pkg;

    localparam int   DEF_WIDTH = 8;
    localparam int   DEF_DEPTH = 3;
    localparam logic SET_BIT   = 1'b1;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_if.sv
// Producer/consumer handshake bundle of dff_pipe.
interface dff_if
    import dff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();

    localparam int CW = cnt_w(DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, q, count
    );

    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, q, count
    );

endinterface

// File: rtl/dff_stage.sv
// One pipeline stage: data/valid register with flush, preload and load enable.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{SET_BIT}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             set_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t st_q, st_d;

    // Arms are made disjoint so clr wins over set, set over load.
    always_comb begin
        st_d = st_q;
        unique case (1'b1)
            clr_i:                   st_d = '0;
            set_i & ~clr_i:          st_d = '{valid: 1'b1, data: SET_VAL};
            en_i & ~set_i & ~clr_i:  st_d = '{valid: valid_i, data: data_i};
            default:                 st_d = st_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st_q <= '0;
        else        st_q <= st_d;
    end

    assign valid_o = st_q.valid;
    assign data_o  = st_q.data;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage stallable register pipeline with bubble collapsing,
// synchronous flush/preload and a registered occupancy count.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{SET_BIT}}
) (
    input logic  clk,
    input logic  reset,
    input logic  set,
    input logic  clr,
    dff_if.slave bus
);

    localparam int CW = cnt_w(DEPTH);

    logic             v    [DEPTH];
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [CW-1:0]    count_q, count_d;

    // A stage may load when it is empty or its downstream neighbour moves.
    always_comb begin
        logic carry;
        carry = bus.out_ready;
        adv   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            carry  = ~v[i] | carry;
            adv[i] = carry;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (i == 0) begin : g_head
            assign up_v = bus.in_valid;
            assign up_d = bus.d;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = data[i-1];
        end

        dff_stage #(
            .WIDTH   (WIDTH),
            .SET_VAL (SET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (clr),
            .set_i   (set),
            .en_i    (adv[i]),
            .valid_i (up_v),
            .data_i  (up_d),
            .valid_o (v[i]),
            .data_o  (data[i])
        );
    end

    assign in_xfer  = bus.in_valid & adv[0];
    assign out_xfer = v[DEPTH-1] & bus.out_ready;

    always_comb begin
        count_d = count_q;
        unique case (1'b1)
            clr:         count_d = '0;
            set & ~clr:  count_d = CW'(DEPTH);
            default:     count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign bus.in_ready  = adv[0] & ~clr & ~set;
    assign bus.out_valid = v[DEPTH-1];
    assign bus.q         = data[DEPTH-1];
    assign bus.count     = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Randomised and directed bench for dff_pipe against a positional queue model.
module tb_dff_pipe;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam logic [W-1:0] SETV = 8'hFF;

    logic clk = 1'b0;
    logic reset;
    logic set;
    logic clr;

    dff_if #(.WIDTH(W), .DEPTH(D)) bus ();

    dff_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .set   (set),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Words in flight, oldest first, with the stage index each occupies.
    logic [W-1:0] mdat[$];
    int           mpos[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (mdat.size() < D || bus.out_ready) && !set && !clr;
    endfunction

    function automatic bit m_ovalid();
        return mpos.size() > 0 && mpos[0] == D - 1;
    endfunction

    task automatic check_all();
        chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ovalid()));
        chk("count", 32'(bus.count), 32'(mdat.size()));
        if (m_ovalid()) chk("q", 32'(bus.q), 32'(mdat[0]));
    endtask

    // Each word steps forward one stage unless the word ahead stays put.
    task automatic model_edge();
        bit acc;
        int lim;
        if (clr) begin
            mdat.delete();
            mpos.delete();
        end else if (set) begin
            mdat.delete();
            mpos.delete();
            for (int i = 0; i < D; i++) begin
                mdat.push_back(SETV);
                mpos.push_back(D - 1 - i);
            end
        end else begin
            acc = bus.in_valid && m_ready();
            lim = bus.out_ready ? D + 1 : D;
            for (int k = 0; k < mpos.size(); k++) begin
                if (mpos[k] + 1 < lim) mpos[k] = mpos[k] + 1;
                lim = mpos[k];
            end
            if (mpos.size() > 0 && mpos[0] == D) begin
                void'(mpos.pop_front());
                void'(mdat.pop_front());
            end
            if (acc) begin
                mdat.push_back(bus.d);
                mpos.push_back(0);
            end
        end
    endtask

    task automatic cyc(input bit iv, input logic [W-1:0] dd, input bit ordy,
                       input bit s = 1'b0, input bit c = 1'b0);
        bus.in_valid  = iv;
        bus.d         = dd;
        bus.out_ready = ordy;
        set           = s;
        clr           = c;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        set           = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.d         = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_q", 32'(bus.q), 32'h0);
        chk("rst_ovalid", 32'(bus.out_valid), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_iready", 32'(bus.in_ready), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming with the consumer always ready.
        cyc(1, 8'h11, 1); chk("s_cnt1", 32'(bus.count), 32'd1);
        cyc(1, 8'h22, 1); chk("s_cnt2", 32'(bus.count), 32'd2);
        cyc(1, 8'h33, 1); chk("s_q11", 32'(bus.q), 32'h11);
        chk("s_cnt3", 32'(bus.count), 32'd3);
        cyc(1, 8'h44, 1); chk("s_q22", 32'(bus.q), 32'h22);
        chk("s_cnt3b", 32'(bus.count), 32'd3);
        cyc(0, 8'h00, 1); chk("s_q33", 32'(bus.q), 32'h33);
        cyc(0, 8'h00, 1); chk("s_q44", 32'(bus.q), 32'h44);
        cyc(0, 8'h00, 1); chk("s_empty", 32'(bus.count), 32'd0);

        // Backpressure fill, then release.
        cyc(1, 8'hA1, 0);
        cyc(1, 8'hA2, 0);
        cyc(1, 8'hA3, 0);
        chk("bp_cnt", 32'(bus.count), 32'd3);
        bus.in_valid = 1'b1; bus.d = 8'hA4; bus.out_ready = 1'b0;
        #1 chk("bp_stall", 32'(bus.in_ready), 32'h0);
        cyc(1, 8'hA4, 0);
        bus.out_ready = 1'b1;
        #1 chk("bp_ripple", 32'(bus.in_ready), 32'h1);
        chk("bp_qA1", 32'(bus.q), 32'hA1);
        cyc(1, 8'hA4, 1); chk("bp_qA2", 32'(bus.q), 32'hA2);
        chk("bp_cnt3", 32'(bus.count), 32'd3);
        cyc(0, 8'h00, 1); chk("bp_qA3", 32'(bus.q), 32'hA3);
        cyc(0, 8'h00, 1); chk("bp_qA4", 32'(bus.q), 32'hA4);
        cyc(0, 8'h00, 1);

        // Bubble collapse behind a stalled word.
        cyc(1, 8'hB1, 0);
        cyc(0, 8'h00, 0);
        cyc(0, 8'h00, 0);
        cyc(1, 8'hB2, 0); chk("bub_cnt", 32'(bus.count), 32'd2);
        chk("bub_qB1", 32'(bus.q), 32'hB1);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 1); chk("bub_qB2", 32'(bus.q), 32'hB2);
        cyc(0, 8'h00, 1);

        // clr beats set; set alone preloads and drops the input.
        cyc(1, 8'hC1, 0);
        cyc(1, 8'hC2, 0);
        cyc(1, 8'hC3, 0, 1, 1);
        chk("clr_cnt", 32'(bus.count), 32'd0);
        chk("clr_ov", 32'(bus.out_valid), 32'h0);
        chk("clr_q", 32'(bus.q), 32'h0);
        cyc(1, 8'hC4, 0, 1, 0);
        chk("set_q", 32'(bus.q), 32'hFF);
        chk("set_ov", 32'(bus.out_valid), 32'h1);
        chk("set_cnt", 32'(bus.count), 32'd3);
        repeat (4) cyc(0, 8'h00, 1);

        // Asynchronous reset between edges.
        cyc(1, 8'hD1, 0);
        cyc(1, 8'hD2, 0);
        chk("ar_pre", 32'(bus.count), 32'd2);
        bus.in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("ar_ov", 32'(bus.out_valid), 32'h0);
        chk("ar_q", 32'(bus.q), 32'h0);
        chk("ar_cnt", 32'(bus.count), 32'd0);
        mdat.delete();
        mpos.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1, 8'hE1, 1);
        cyc(1, 8'hE2, 1);
        cyc(1, 8'hE3, 1); chk("ar_qE1", 32'(bus.q), 32'hE1);
        repeat (3) cyc(0, 8'h00, 1);

        // Random traffic with rare flush/preload.
        for (int n = 0; n < 2000; n++) begin
            cyc($urandom_range(0, 3) != 0,
                W'($urandom),
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 59) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
